// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute, drives datapath
// selects and strobes, and bounds memory handshakes with a wait-cycle timeout.
module mips_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             wait_state;
  logic             timeout_hit;
  logic             funct_ok;

  assign state      = state_q;
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign funct_ok   = (funct == FN_ADD) || (funct == FN_SUB) ||
                      (funct == FN_AND) || (funct == FN_OR);
  // Last allowed wait cycle; a concurrent mem_ready still completes normally.
  assign timeout_hit = (MEM_TIMEOUT != 0) && wait_state && !mem_ready &&
                       (32'(wait_cnt_q) == MEM_TIMEOUT - 1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Wait counter: zero outside wait states and whenever a wait state is left
  always_ff @(posedge clk) begin
    if (reset || !wait_state || mem_ready || timeout_hit) wait_cnt_q <= '0;
    else                                                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : (timeout_hit ? S_FETCH : S_FETCH);
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : (timeout_hit ? S_FETCH : S_MEMRD);
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = (mem_ready || timeout_hit) ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    illegal_op = 1'b0;
    bus_error  = timeout_hit;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
          OP_RTYPE:                            illegal_op = !funct_ok;
          default:                             illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        unique case (funct)
          FN_SUB:  alu_op = 2'b01;
          FN_AND:  alu_op = 2'b10;
          FN_OR:   alu_op = 2'b11;
          default: alu_op = 2'b00;
        endcase
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    // A reset cycle must never commit anything to memory, registers or PC
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      pc_en      = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control (MEM_TIMEOUT=4): state sequences,
// output vectors per state, memory wait/timeout, illegal opcode and reset.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op, bus_error;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en), .illegal_op(illegal_op),
    .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  // {state, mr, mw, iord, irw, rdst, m2r, rw, asa, asb[2], aop[2], psrc[2], pce, ill, berr}
  logic [20:0] got;
  assign got = {state, mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, bus_error};

  localparam logic [20:0] E_FETCH_R  = {4'd0,  17'b1_0_0_1_0_0_0_0_01_00_00_1_0_0};
  localparam logic [20:0] E_FETCH_W  = {4'd0,  17'b1_0_0_0_0_0_0_0_01_00_00_0_0_0};
  localparam logic [20:0] E_DECODE   = {4'd1,  17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0};
  localparam logic [20:0] E_DEC_ILL  = {4'd1,  17'b0_0_0_0_0_0_0_0_11_00_00_0_1_0};
  localparam logic [20:0] E_MEMADR   = {4'd2,  17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0};
  localparam logic [20:0] E_MEMRD    = {4'd3,  17'b1_0_1_0_0_0_0_0_00_00_00_0_0_0};
  localparam logic [20:0] E_MEMWB    = {4'd4,  17'b0_0_0_0_0_1_1_0_00_00_00_0_0_0};
  localparam logic [20:0] E_MEMWR    = {4'd5,  17'b0_1_1_0_0_0_0_0_00_00_00_0_0_0};
  localparam logic [20:0] E_MEMWR_TO = {4'd5,  17'b0_1_1_0_0_0_0_0_00_00_00_0_0_1};
  localparam logic [20:0] E_EXEC_SUB = {4'd6,  17'b0_0_0_0_0_0_0_1_00_01_00_0_0_0};
  localparam logic [20:0] E_ALUWB    = {4'd7,  17'b0_0_0_0_1_0_1_0_00_00_00_0_0_0};
  localparam logic [20:0] E_BR_TAKEN = {4'd8,  17'b0_0_0_0_0_0_0_1_00_01_01_1_0_0};
  localparam logic [20:0] E_BR_NOT   = {4'd8,  17'b0_0_0_0_0_0_0_1_00_01_01_0_0_0};
  localparam logic [20:0] E_JUMP     = {4'd9,  17'b0_0_0_0_0_0_0_0_00_00_10_1_0_0};
  localparam logic [20:0] E_ADDIEX   = {4'd10, 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0};
  localparam logic [20:0] E_ADDIWB   = {4'd11, 17'b0_0_0_0_0_0_1_0_00_00_00_0_0_0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] strobes;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
    step(); step();
    #1;
    strobes = {mem_read, mem_write, ir_write, reg_write, pc_en, illegal_op, bus_error};
    checks++;
    if (state !== 4'd0 || strobes !== 7'd0) begin
      errors++;
      $display("FAIL reset: state=%0d strobes=%b, expected state=0 strobes=0000000", state, strobes);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (got !== E_FETCH_R) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", got, E_FETCH_R);
    end
  endtask

  task automatic test_lw();
    logic [20:0] exp [6];
    exp = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH_R};
    opcode = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL lw[%0d]: got %h expected %h", i, got, exp[i]);
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_rtype();
    logic [20:0] exp [5];
    logic [5:0]  fn [3];
    logic [1:0]  aop [3];
    exp = '{E_FETCH_R, E_DECODE, E_EXEC_SUB, E_ALUWB, E_FETCH_R};
    opcode = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL rtype_sub[%0d]: got %h expected %h", i, got, exp[i]);
      end
      if (i < 4) step();
    end
    fn  = '{6'b100000, 6'b100100, 6'b100101};
    aop = '{2'b00, 2'b10, 2'b11};
    for (int k = 0; k < 3; k++) begin
      funct = fn[k];
      step(); step();
      #1;
      checks++;
      if (state !== 4'd6 || alu_op !== aop[k]) begin
        errors++;
        $display("FAIL rtype_aluop funct=%b: state=%0d alu_op=%b expected state=6 alu_op=%b",
                 fn[k], state, alu_op, aop[k]);
      end
      step(); step();
    end
  endtask

  task automatic test_branch();
    logic [20:0] exp_br [2];
    exp_br = '{E_BR_TAKEN, E_BR_NOT};
    opcode = 6'b000100; mem_ready = 1'b1;
    for (int z = 0; z < 2; z++) begin
      zero = (z == 0);
      step(); step();
      #1;
      checks++;
      if (got !== exp_br[z]) begin
        errors++;
        $display("FAIL beq zero=%0b: got %h expected %h", zero, got, exp_br[z]);
      end
      step();
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_jump();
    logic [20:0] exp [4];
    exp = '{E_FETCH_R, E_DECODE, E_ADDIEX, E_ADDIWB};
    opcode = 6'b001000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL addi[%0d]: got %h expected %h", i, got, exp[i]);
      end
      step();
    end
    opcode = 6'b000010;
    step(); step();
    #1;
    checks++;
    if (got !== E_JUMP) begin
      errors++;
      $display("FAIL jump: got %h expected %h", got, E_JUMP);
    end
    step();
  endtask

  task automatic test_fetch_wait();
    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      checks++;
      if (got !== ((i == 3) ? E_FETCH_R : E_FETCH_W)) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: got %h expected %h", i, got,
                 (i == 3) ? E_FETCH_R : E_FETCH_W);
      end
      step();
    end
    #1;
    checks++;
    if (got !== E_DECODE) begin
      errors++;
      $display("FAIL fetch_wait_exit: got %h expected %h", got, E_DECODE);
    end
    step(); step();
  endtask

  task automatic test_timeout();
    opcode = 6'b101011; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (got !== ((i == 3) ? E_MEMWR_TO : E_MEMWR)) begin
        errors++;
        $display("FAIL sw_timeout[%0d]: got %h expected %h", i, got,
                 (i == 3) ? E_MEMWR_TO : E_MEMWR);
      end
      step();
    end
    #1;
    checks++;
    if (got !== E_FETCH_W) begin
      errors++;
      $display("FAIL timeout_refetch: got %h expected %h", got, E_FETCH_W);
    end
    mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    step();
    #1;
    checks++;
    if (got !== E_DEC_ILL) begin
      errors++;
      $display("FAIL illegal_decode: got %h expected %h", got, E_DEC_ILL);
    end
    step();
    #1;
    checks++;
    if (got !== E_FETCH_R) begin
      errors++;
      $display("FAIL illegal_return: got %h expected %h", got, E_FETCH_R);
    end
    opcode = 6'b000000; funct = 6'b101010;
    step();
    #1;
    checks++;
    if (illegal_op !== 1'b1 || state !== 4'd1) begin
      errors++;
      $display("FAIL illegal_funct: state=%0d illegal_op=%b expected state=1 illegal_op=1",
               state, illegal_op);
    end
    step();
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step();
    #1;
    checks++;
    if (got !== E_MEMRD) begin
      errors++;
      $display("FAIL memrd_wait: got %h expected %h", got, E_MEMRD);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || state !== 4'd3) begin
      errors++;
      $display("FAIL reset_cycle: state=%0d mem_read=%b expected state=3 mem_read=0",
               state, mem_read);
    end
    step();
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (got !== E_FETCH_R) begin
      errors++;
      $display("FAIL reset_mid_memrd: got %h expected %h", got, E_FETCH_R);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_addi_jump();
    test_fetch_wait();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
